// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: runs a req/ack handshake with a
// variable-latency data memory and stalls the upstream pipeline meanwhile.
module dmem_access_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [ADDR_W-1:0] result_i,
   input  logic [DATA_W-1:0] write_data_i,
   input  logic              reg_write_i,
   input  logic              mem_to_reg_i,
   input  logic [4:0]        write_reg_i,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] read_data_o,
   output logic [ADDR_W-1:0] result_o,
   output logic [4:0]        write_reg_o,
   output logic              reg_write_o,
   output logic              mem_to_reg_o,
   output logic              stall_o,
   output logic              err_o
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

   state_t            state;
   logic [7:0]        waitCnt;
   logic [DATA_W-1:0] rdataReg;
   logic              acc;

   assign acc = mem_read_i | mem_write_i;

   // Ack wins over timeout when both land in the final wait cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         waitCnt   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdataReg  <= '0;
         err_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  mem_addr  <= result_i;
                  mem_wdata <= write_data_i;
                  mem_we    <= mem_write_i;
                  mem_req   <= 1'b1;
                  waitCnt   <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               waitCnt <= waitCnt + 8'd1;
               if (mem_ack) begin
                  rdataReg <= mem_we ? '0 : mem_rdata;
                  mem_req  <= 1'b0;
                  state    <= DONE;
               end else if (waitCnt == LAST_WAIT) begin
                  rdataReg <= '0;
                  mem_req  <= 1'b0;
                  err_o    <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               waitCnt <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_o      = ~reset & (((state == IDLE) & acc) | (state == REQ));
   assign reg_write_o  = reg_write_i & ~stall_o & ~reset;
   assign read_data_o  = (state == DONE) ? rdataReg : '0;
   assign result_o     = result_i;
   assign write_reg_o  = write_reg_i;
   assign mem_to_reg_o = mem_to_reg_i;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: each access is modelled as a timeline
// (one detect cycle, N request cycles, one completion cycle).
module tb_dmem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
   logic [31:0] result_i, write_data_i;
   logic [4:0]  write_reg_i;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, read_data_o, result_o;
   logic [4:0]  write_reg_o;
   logic        reg_write_o, mem_to_reg_o, stall_o, err_o;

   dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .result_i(result_i), .write_data_i(write_data_i),
      .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
      .write_reg_i(write_reg_i),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .read_data_o(read_data_o), .result_o(result_o),
      .write_reg_o(write_reg_o), .reg_write_o(reg_write_o),
      .mem_to_reg_o(mem_to_reg_o), .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int stallCycles = 0;
   int reqCycles = 0;
   logic [31:0] doneRead;

   logic        checkEn = 1'b0;
   logic        inTransit = 1'b0;
   logic        expStall, expReq, expWe, expRegWrite, expErr, expMemToReg;
   logic [31:0] expAddr, expWdata, expReadData, expResult;
   logic [4:0]  expWriteReg;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Single compare point, mid-cycle, against the timeline expectations.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("stall", stall_o, expStall);
         checkOutput("regWrite", reg_write_o, expRegWrite);
         checkOutput("err", err_o, expErr);
         checkOutput("result", result_o, expResult);
         checkOutput("writeReg", write_reg_o, expWriteReg);
         checkOutput("memToReg", mem_to_reg_o, expMemToReg);
         if (!inTransit) begin
            checkOutput("memReq", mem_req, expReq);
            if (expReq) begin
               checkOutput("memWe", mem_we, expWe);
               checkOutput("memAddr", mem_addr, expAddr);
               checkOutput("memWdata", mem_wdata, expWdata);
            end
            if (!expStall) checkOutput("readData", read_data_o, expReadData);
         end
         if (stall_o) stallCycles++;
         if (mem_req) reqCycles++;
      end
   end

   task automatic setInputs(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic regw);
      mem_read_i   = rd;
      mem_write_i  = wr;
      result_i     = addr;
      write_data_i = wdata;
      reg_write_i  = regw;
      mem_to_reg_i = 1'($urandom);
      write_reg_i  = 5'($urandom);
      expResult    = addr;
      expMemToReg  = mem_to_reg_i;
      expWriteReg  = write_reg_i;
   endtask

   // One EX/MEM instruction; lat = idle REQ cycles before ack (>= TO means no ack).
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic regw,
                                input int lat, input logic [31:0] rdata);
      int n;
      logic acked;
      setInputs(rd, wr, addr, wdata, regw);
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      if (!(rd | wr)) begin
         expStall = 1'b0; expReq = 1'b0; expRegWrite = regw; expReadData = '0;
         @(posedge clk); #1;
         return;
      end
      acked = (lat + 1 <= TO);
      n = acked ? lat + 1 : TO;
      expStall = 1'b1; expReq = 1'b0; expRegWrite = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= n; k++) begin
         mem_ack   = acked && (k == n);
         mem_rdata = (acked && k == n) ? rdata : $urandom;
         expReq = 1'b1; expWe = wr; expAddr = addr; expWdata = wdata; expStall = 1'b1;
         @(posedge clk); #1;
      end
      mem_ack     = 1'($urandom);
      mem_rdata   = $urandom;
      expReq      = 1'b0;
      expStall    = 1'b0;
      expRegWrite = regw;
      expReadData = (acked && !wr) ? rdata : 32'h0;
      if (!acked) expErr = 1'b1;
      @(negedge clk);
      doneRead = read_data_o;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      setInputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(posedge clk); #1;
      expStall = 1'b0; expRegWrite = 1'b0; expReq = 1'b0; expErr = 1'b0; expReadData = '0;
      checkEn = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 0, 32'h0);
      checkOutput("noacc_req_cycles", reqCycles, 0);

      stallCycles = 0; reqCycles = 0;
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 0, 32'hDEADBEEF);
      checkOutput("load0_stalls", stallCycles, 2);
      checkOutput("load0_req_cycles", reqCycles, 1);
      checkOutput("load0_data", doneRead, 32'hDEADBEEF);

      stallCycles = 0; reqCycles = 0;
      applyStimulus(1'b0, 1'b1, 32'h44, 32'h12345678, 1'b0, 3, 32'hCAFEF00D);
      checkOutput("store3_stalls", stallCycles, 5);
      checkOutput("store3_req_cycles", reqCycles, 4);
      checkOutput("store3_data", doneRead, 32'h0);

      stallCycles = 0;
      applyStimulus(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1, 32'h0BADF00D);
      checkOutput("b2b_first_data", doneRead, 32'h0BADF00D);
      applyStimulus(1'b1, 1'b0, 32'h4C, 32'h0, 1'b1, 2, 32'h13579BDF);
      checkOutput("b2b_second_data", doneRead, 32'h13579BDF);
      checkOutput("b2b_stalls", stallCycles, 7);

      checkOutput("err_before_timeout", err_o, 1'b0);
      stallCycles = 0; reqCycles = 0;
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 50, 32'hFFFFFFFF);
      checkOutput("timeout_stalls", stallCycles, 5);
      checkOutput("timeout_req_cycles", reqCycles, TO);
      checkOutput("timeout_data", doneRead, 32'h0);
      checkOutput("timeout_err", err_o, 1'b1);

      for (int t = 0; t < 40; t++) begin
         applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                       int'($urandom_range(0, 6)), $urandom);
      end
      checkOutput("err_sticky", err_o, 1'b1);

      // Reset lands in the second REQ cycle of a load.
      setInputs(1'b1, 1'b0, 32'h90, 32'h0, 1'b1);
      mem_ack = 1'b0;
      expStall = 1'b1; expReq = 1'b0; expRegWrite = 1'b0;
      @(posedge clk); #1;
      expReq = 1'b1; expWe = 1'b0; expAddr = 32'h90; expWdata = 32'h0;
      @(posedge clk); #1;
      reset = 1'b1;
      inTransit = 1'b1;
      expStall = 1'b0; expRegWrite = 1'b0;
      @(posedge clk); #1;
      inTransit = 1'b0;
      expReq = 1'b0; expErr = 1'b0; expReadData = '0;
      checkOutput("rst_mid_req", mem_req, 1'b0);
      checkOutput("rst_mid_err", err_o, 1'b0);
      setInputs(1'b0, 1'b0, 32'h94, 32'h0, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h98, 32'h0, 1'b1, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h9C, 32'h0, 1'b1, 0, 32'h2468ACE0);
      checkOutput("post_reset_load", doneRead, 32'h2468ACE0);

      checkEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB register, and produces the MEM-stage bundle that MEM/WB latches.
- Drives a variable-latency data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- While stalled, the write-back enable toward MEM/WB is suppressed, so no bubble cycle writes the register file.

Parameters:
- ADDR_W, 32, address and ALU-result width
- DATA_W, 32, data width
- TIMEOUT_CYC, 64, maximum REQ cycles waited for mem_ack before aborting the access (valid range 1..255)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- mem_read_i  in  1  EX/MEM MemRead
- mem_write_i  in  1  EX/MEM MemWrite
- result_i  in  ADDR_W  EX/MEM ALU result; used as the memory address
- write_data_i  in  DATA_W  EX/MEM store data
- reg_write_i  in  1  EX/MEM RegWrite
- mem_to_reg_i  in  1  EX/MEM MemtoReg
- write_reg_i  in  5  EX/MEM destination register
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- read_data_o  out  DATA_W  to MEM/WB ReadData input
- result_o  out  ADDR_W  to MEM/WB Result input; equals result_i
- write_reg_o  out  5  to MEM/WB WriteReg input; equals write_reg_i
- reg_write_o  out  1  to MEM/WB RegWrite input
- mem_to_reg_o  out  1  to MEM/WB MemtoReg input; equals mem_to_reg_i
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state=IDLE, timeout counter=0, and the registered outputs mem_req, mem_we, mem_addr, mem_wdata, read-data register and err_o all become 0.
- Combinational outputs during reset: stall_o=0 and reg_write_o=0.
- A memory access is present when acc = mem_read_i | mem_write_i. If both are set, the access is a write.
- IDLE state:
  - acc=0: no stall; read_data_o=0; reg_write_o=reg_write_i (pure pass-through).
  - acc=1: stall_o=1. At the next edge, latch mem_addr=result_i, mem_wdata=write_data_i and mem_we=mem_write_i, set mem_req=1, and go to REQ.
- REQ state:
  - stall_o=1. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Counter increments every REQ cycle.
  - mem_ack=1: latch rdata = (mem_we ? 0 : mem_rdata), set mem_req=0, go to DONE.
  - Counter reaches TIMEOUT_CYC with no ack: rdata=0, mem_req=0, err_o=1, go to DONE.
- DONE state:
  - stall_o=0; read_data_o = latched rdata.
  - MEM/WB captures the access at the end of this cycle, and EX/MEM advances.
  - Counter clears; go to IDLE.
- Back-to-back accesses: the next access is detected in IDLE on the following cycle.
- Write-back suppression: reg_write_o = reg_write_i & ~stall_o in all states.
- Latency: with ack in the first REQ cycle, an access takes 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles. Every additional wait cycle adds one stall cycle.
- mem_ack outside REQ is ignored.
- err_o is cleared only by reset.
- Reset during REQ: mem_req drops at that edge and no completion is reported.
- Changes on the inputs while stall_o=1 are ignored; EX/MEM holds the inputs stable by contract.

Test Plan:
- No access: reg_write_i=1, result_i=0x10, mem_read/mem_write=0 -> stall_o=0, result_o=0x10, reg_write_o=1, read_data_o=0, mem_req never asserts.
- Load, zero-wait: mem_read_i=1, result_i=0x40, memory acks in the first REQ cycle with 0xDEADBEEF:
  - stall_o=1 for exactly 2 cycles, then read_data_o=0xDEADBEEF in DONE with stall_o=0.
  - mem_addr=0x40 and mem_we=0 while mem_req=1.
- Store, 3-wait: mem_write_i=1, write_data_i=0x12345678, ack after 3 REQ cycles:
  - mem_req high for 4 cycles with mem_we=1 and mem_wdata=0x12345678 held.
  - stall_o=1 for 5 cycles; read_data_o=0 in DONE.
- Timeout: TIMEOUT_CYC=4, load with no ack -> mem_req high for 4 cycles; in DONE, err_o=1, read_data_o=0 and stall_o=0; err_o stays 1 until reset.
- Back-to-back loads plus reset mid-access:
  - Two consecutive loads each complete (IDLE, REQ, DONE) with a correct read_data_o, and reg_write_o=0 in every stall cycle.
  - A third load is reset in its REQ state -> at that edge mem_req=0, err_o=0 and state=IDLE; while reset is high, stall_o=0 and reg_write_o=0.
